// File: rtl/branch_ctrl_pkg.sv
// Shared decode constants, FSM state type and branch target helper for the ID-stage branch controller.
package branch_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SLOT  = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  function automatic logic [31:0] br_target(input logic [31:0] pc4, input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational decode of control-transfer ops: taken condition, operand needs and target kind.
module branch_cond
  import branch_ctrl_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rt,
  input  logic [5:0]  i_funct,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic        o_ctrl,
  output logic        o_taken,
  output logic        o_need_rs,
  output logic        o_need_rt,
  output logic        o_is_j,
  output logic        o_is_jr
);

  logic w_rs_neg;
  logic w_rs_zero;
  logic w_eq;

  assign w_rs_neg  = i_rs_val[31];
  assign w_rs_zero = (i_rs_val == 32'd0);
  assign w_eq      = (i_rs_val == i_rt_val);

  always_comb begin
    o_ctrl    = 1'b0;
    o_taken   = 1'b0;
    o_need_rs = 1'b0;
    o_need_rt = 1'b0;
    o_is_j    = 1'b0;
    o_is_jr   = 1'b0;
    case (i_op)
      OP_BEQ: begin
        o_ctrl = 1'b1; o_need_rs = 1'b1; o_need_rt = 1'b1; o_taken = w_eq;
      end
      OP_BNE: begin
        o_ctrl = 1'b1; o_need_rs = 1'b1; o_need_rt = 1'b1; o_taken = !w_eq;
      end
      OP_BLEZ: begin
        o_ctrl = 1'b1; o_need_rs = 1'b1; o_taken = w_rs_neg | w_rs_zero;
      end
      OP_BGTZ: begin
        o_ctrl = 1'b1; o_need_rs = 1'b1; o_taken = !w_rs_neg & !w_rs_zero;
      end
      OP_REGIMM: begin
        // Only bltz/bgez are recognised; other REGIMM forms fall through as non-control.
        if (i_rt == RT_BLTZ) begin
          o_ctrl = 1'b1; o_need_rs = 1'b1; o_taken = w_rs_neg;
        end else if (i_rt == RT_BGEZ) begin
          o_ctrl = 1'b1; o_need_rs = 1'b1; o_taken = !w_rs_neg;
        end
      end
      OP_J, OP_JAL: begin
        o_ctrl = 1'b1; o_taken = 1'b1; o_is_j = 1'b1;
      end
      OP_SPECIAL: begin
        if (i_funct == FN_JR) begin
          o_ctrl = 1'b1; o_need_rs = 1'b1; o_taken = 1'b1; o_is_jr = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls for operands, resolves in the ready cycle, waits for the delay
// slot, then holds a registered redirect (pc/valid stable) until fetch asserts redirect_ready.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        slot_valid,
  input  logic        flush,
  output logic        id_stall,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        br_taken
);

  state_t      r_state;
  logic [31:0] r_target;
  logic        r_redir_vld;

  logic        w_ctrl;
  logic        w_taken;
  logic        w_need_rs;
  logic        w_need_rt;
  logic        w_is_j;
  logic        w_is_jr;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_eval;
  logic        w_hit;
  logic        w_ops_ok;
  logic        w_resolve;

  branch_cond u_cond (
    .i_op      (id_inst[31:26]),
    .i_rt      (id_inst[20:16]),
    .i_funct   (id_inst[5:0]),
    .i_rs_val  (rs_val),
    .i_rt_val  (rt_val),
    .o_ctrl    (w_ctrl),
    .o_taken   (w_taken),
    .o_need_rs (w_need_rs),
    .o_need_rt (w_need_rt),
    .o_is_j    (w_is_j),
    .o_is_jr   (w_is_jr)
  );

  assign w_pc4 = id_pc + 32'd4;

  always_comb begin
    w_target = br_target(w_pc4, id_inst[15:0]);
    if (w_is_jr) begin
      w_target = rs_val;
    end else if (w_is_j) begin
      w_target = {w_pc4[31:28], id_inst[25:0], 2'b00};
    end
  end

  // Instructions in ID are only evaluated before a transfer is pending; SLOT ignores them.
  assign w_eval    = (r_state == ST_IDLE) || (r_state == ST_WAIT);
  assign w_hit     = w_eval & id_valid & w_ctrl;
  assign w_ops_ok  = (!w_need_rs | rs_ready) & (!w_need_rt | rt_ready);
  assign w_resolve = w_hit & w_ops_ok & w_taken & !flush;

  assign br_taken       = w_resolve & !rst;
  assign id_stall       = !rst & ((r_state == ST_REDIR) | (w_hit & !w_ops_ok));
  assign redirect_valid = r_redir_vld;
  assign redirect_pc    = r_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_target    <= 32'd0;
      r_redir_vld <= 1'b0;
    end else if (flush) begin
      // A flush coinciding with redirect_ready still ends in IDLE, so the handshake completes.
      r_state     <= ST_IDLE;
      r_target    <= 32'd0;
      r_redir_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WAIT: begin
          if (w_hit && !w_ops_ok) begin
            r_state <= ST_WAIT;
          end else if (w_resolve) begin
            r_state  <= ST_SLOT;
            r_target <= w_target;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SLOT: begin
          if (slot_valid) begin
            r_state     <= ST_REDIR;
            r_redir_vld <= 1'b1;
          end
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            r_state     <= ST_IDLE;
            r_redir_vld <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
